// File: rtl/zap_ram_pipe_pkg.sv
// zap_ram_pipe_pkg: shared types and helpers for the pipelined byte-enable RAM.
//   state_e    : clear-sequencer states (StClear, StRun)
//   MAX_RD_LAT : upper bound on the configurable read latency
//   merge()    : byte select under a single byte-enable bit
package zap_ram_pipe_pkg;

  localparam int unsigned MAX_RD_LAT = 8;

  typedef enum logic [0:0] {
    StClear,
    StRun
  } state_e;

  // Returns new_byte when ben is set, otherwise old_byte.
  function automatic logic [7:0] merge(input logic [7:0] old_byte,
                                       input logic [7:0] new_byte,
                                       input logic       ben);
    return ben ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/zap_ram_pipe_ben_if.sv
// zap_ram_pipe_ben_if: request/response bundle of the pipelined byte-enable RAM.
//   i_clken                     global clock enable
//   i_wr_en/i_wr_addr/i_wr_data per-byte write port
//   i_rd_en/i_rd_addr           read request
//   o_rd_data_pre               final-stage data, one cycle ahead of o_rd_data
//   o_rd_data/o_rd_valid        registered read response
//   o_busy                      clear sequencer active
//   o_par_err                   per-byte parity error (only with ZAP_RAM_PIPE_PARITY_EN)
// master: requester side; slave: RAM side.
interface zap_ram_pipe_ben_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
);
  localparam int unsigned NB = WIDTH / 8;
  localparam int unsigned AW = $clog2(DEPTH);

  logic             i_clken;
  logic [NB-1:0]    i_wr_en;
  logic [AW-1:0]    i_wr_addr;
  logic [WIDTH-1:0] i_wr_data;
  logic             i_rd_en;
  logic [AW-1:0]    i_rd_addr;
  logic [WIDTH-1:0] o_rd_data_pre;
  logic [WIDTH-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_busy;
`ifdef ZAP_RAM_PIPE_PARITY_EN
  logic [NB-1:0]    o_par_err;
`endif

  modport master (
    output i_clken, i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    input  o_rd_data_pre, o_rd_data, o_rd_valid, o_busy
`ifdef ZAP_RAM_PIPE_PARITY_EN
    , input o_par_err
`endif
  );

  modport slave (
    input  i_clken, i_wr_en, i_wr_addr, i_wr_data, i_rd_en, i_rd_addr,
    output o_rd_data_pre, o_rd_data, o_rd_valid, o_busy
`ifdef ZAP_RAM_PIPE_PARITY_EN
    , output o_par_err
`endif
  );

endinterface

// File: rtl/zap_ram_fwd_stage.sv
// zap_ram_fwd_stage: one read-pipeline register stage with bytewise write forwarding.
//   i_clk, i_reset_n                      clock, synchronous active-low reset
//   i_clken                               stage advance enable (stall when low)
//   i_fwd_en/i_fwd_addr/i_fwd_data        write accepted this cycle (enables pre-gated)
//   i_data/i_addr/i_valid                 previous stage
//   o_data/o_addr/o_valid                 this stage
//   i_err/o_err                           parity error bits (only with ZAP_RAM_PIPE_PARITY_EN)
module zap_ram_fwd_stage
  import zap_ram_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clken,
  input  logic [WIDTH/8-1:0] i_fwd_en,
  input  logic [AW-1:0]      i_fwd_addr,
  input  logic [WIDTH-1:0]   i_fwd_data,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [AW-1:0]      i_addr,
  input  logic               i_valid,
`ifdef ZAP_RAM_PIPE_PARITY_EN
  input  logic [WIDTH/8-1:0] i_err,
  output logic [WIDTH/8-1:0] o_err,
`endif
  output logic [WIDTH-1:0]   o_data,
  output logic [AW-1:0]      o_addr,
  output logic               o_valid
);
  localparam int unsigned NB = WIDTH / 8;

  logic [NB-1:0]    fwd_sel;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    fwd_sel = '0;
    data_d  = i_data;
    for (int k = 0; k < NB; k++) begin
      fwd_sel[k]       = i_fwd_en[k] && (i_fwd_addr == i_addr);
      data_d[k*8 +: 8] = merge(i_data[k*8 +: 8], i_fwd_data[k*8 +: 8], fwd_sel[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
`ifdef ZAP_RAM_PIPE_PARITY_EN
      o_err   <= '0;
`endif
    end else if (i_clken) begin
      o_valid <= i_valid;
      o_data  <= data_d;
      o_addr  <= i_addr;
`ifdef ZAP_RAM_PIPE_PARITY_EN
      // A forwarded byte is fresh write data, so its array parity no longer applies.
      o_err   <= i_err & ~fwd_sel;
`endif
    end
  end

endmodule

// File: rtl/zap_ram_pipe_ben.sv
// zap_ram_pipe_ben: pipelined byte-enable simple dual-port RAM (1W/1R) with
// RD_LAT-cycle reads, bytewise write-to-read forwarding at every stage, read-valid
// tracking and a reset-time clear sequencer.
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   bus        zap_ram_pipe_ben_if.slave (write/read request, read response, busy)
// Optional: define ZAP_RAM_PIPE_PARITY_EN for per-byte even parity and bus.o_par_err.
module zap_ram_pipe_ben
  import zap_ram_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 32,
  parameter int unsigned      RD_LAT   = 3,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic               i_clk,
  input logic               i_reset_n,
  zap_ram_pipe_ben_if.slave bus
);
  localparam int unsigned NB   = WIDTH / 8;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned LAST = RD_LAT - 1;

  if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_bad_width
    $fatal(1, "zap_ram_pipe_ben: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $fatal(1, "zap_ram_pipe_ben: DEPTH must be at least 2");
  end
  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $fatal(1, "zap_ram_pipe_ben: RD_LAT must be in 1..8");
  end

  // Clear sequencer
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;
  logic          busy;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: ;
      default: state_d = StClear;
    endcase
  end

  assign busy = (state_q == StClear);

  // Requests only take effect when enabled and not clearing.
  logic          accept;
  logic [NB-1:0] wr_ben;

  assign accept = bus.i_clken && !busy;
  assign wr_ben = accept ? bus.i_wr_en : '0;

  // Storage; reset leaves contents alone, only the clear sequencer initialises them.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (clr_we) begin
        mem[cnt_q] <= INIT_VAL;
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (wr_ben[k]) mem[bus.i_wr_addr][k*8 +: 8] <= bus.i_wr_data[k*8 +: 8];
        end
      end
    end
  end

`ifdef ZAP_RAM_PIPE_PARITY_EN
  function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] w);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) p[k] = ^w[k*8 +: 8];
    return p;
  endfunction

  logic [NB-1:0] par_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      if (clr_we) begin
        par_mem[cnt_q] <= byte_par(INIT_VAL);
      end else begin
        for (int k = 0; k < NB; k++) begin
          if (wr_ben[k]) par_mem[bus.i_wr_addr][k] <= ^bus.i_wr_data[k*8 +: 8];
        end
      end
    end
  end
`endif

  // Stage 0 is the combinational array read; stages 1..RD_LAT-1 are registers.
  logic [WIDTH-1:0] st_data  [RD_LAT];
  logic [AW-1:0]    st_addr  [RD_LAT];
  logic             st_valid [RD_LAT];
`ifdef ZAP_RAM_PIPE_PARITY_EN
  logic [NB-1:0]    st_err   [RD_LAT];
  assign st_err[0] = par_mem[bus.i_rd_addr] ^ byte_par(mem[bus.i_rd_addr]);
`endif

  assign st_data[0]  = mem[bus.i_rd_addr];
  assign st_addr[0]  = bus.i_rd_addr;
  assign st_valid[0] = accept && bus.i_rd_en;

  for (genvar i = 1; i < RD_LAT; i++) begin : g_stage
    zap_ram_fwd_stage #(
      .WIDTH (WIDTH),
      .AW    (AW)
    ) u_stage (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_clken    (bus.i_clken),
      .i_fwd_en   (wr_ben),
      .i_fwd_addr (bus.i_wr_addr),
      .i_fwd_data (bus.i_wr_data),
      .i_data     (st_data[i-1]),
      .i_addr     (st_addr[i-1]),
      .i_valid    (st_valid[i-1]),
`ifdef ZAP_RAM_PIPE_PARITY_EN
      .i_err      (st_err[i-1]),
      .o_err      (st_err[i]),
`endif
      .o_data     (st_data[i]),
      .o_addr     (st_addr[i]),
      .o_valid    (st_valid[i])
    );
  end

  // Output register: last forwarding point (write accepted in the final cycle).
  logic [NB-1:0]    out_sel;
  logic [WIDTH-1:0] rd_data_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;

  always_comb begin
    out_sel   = '0;
    rd_data_d = st_data[LAST];
    for (int k = 0; k < NB; k++) begin
      out_sel[k]          = wr_ben[k] && (bus.i_wr_addr == st_addr[LAST]);
      rd_data_d[k*8 +: 8] = merge(st_data[LAST][k*8 +: 8], bus.i_wr_data[k*8 +: 8],
                                  out_sel[k]);
    end
  end

`ifdef ZAP_RAM_PIPE_PARITY_EN
  logic [NB-1:0] par_err_q;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
`ifdef ZAP_RAM_PIPE_PARITY_EN
      par_err_q  <= '0;
`endif
    end else if (bus.i_clken) begin
      rd_valid_q <= st_valid[LAST];
      // Idle slots leave the last returned word in place.
      if (st_valid[LAST]) begin
        rd_data_q <= rd_data_d;
`ifdef ZAP_RAM_PIPE_PARITY_EN
        par_err_q <= st_err[LAST] & ~out_sel;
`endif
      end
    end
  end

  assign bus.o_rd_data_pre = st_data[LAST];
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_rd_valid    = rd_valid_q;
  assign bus.o_busy        = busy;
`ifdef ZAP_RAM_PIPE_PARITY_EN
  assign bus.o_par_err     = par_err_q;
`endif

endmodule

// File: tb/tb_zap_ram_pipe_ben.sv
// tb_zap_ram_pipe_ben: drives three instances (RD_LAT = 3, 1, 8) with one stimulus
// stream. A reference model logs accepted reads/writes per enabled cycle; one monitor
// per instance computes each expected response from that log and compares.
module tb_zap_ram_pipe_ben;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] INIT  = 32'h5AC3_0F96;
  localparam int          MAXN  = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clken;
  logic [3:0]  wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [4:0]  rd_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mem_m [DEPTH];
  logic [3:0]  bad_m [DEPTH];
  int          clr_rem   = 0;
  int          en_cnt    = 0;
  int          edge_kind = -1;  // 0 reset, 1 enabled, 2 stalled
  int          edge_idx  = 0;
  logic [3:0]  wl_en   [MAXN];
  logic [4:0]  wl_addr [MAXN];
  logic [31:0] wl_data [MAXN];
  int          rd_cnt  = 0;
  int          rd_n    [MAXN];
  logic [4:0]  rd_a    [MAXN];
  logic [31:0] rd_base [MAXN];
  logic [3:0]  rd_bad  [MAXN];

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_kind = 0;
      clr_rem   = DEPTH;
    end else begin
      if (clken && en_cnt < MAXN) begin
        edge_kind        = 1;
        edge_idx         = en_cnt;
        wl_en[en_cnt]    = (clr_rem == 0) ? wr_en : 4'h0;
        wl_addr[en_cnt]  = wr_addr;
        wl_data[en_cnt]  = wr_data;
        if (clr_rem == 0 && rd_en && rd_cnt < MAXN) begin
          rd_n[rd_cnt]    = en_cnt;
          rd_a[rd_cnt]    = rd_addr;
          rd_base[rd_cnt] = mem_m[rd_addr];
          rd_bad[rd_cnt]  = bad_m[rd_addr];
          rd_cnt++;
        end
        if (clr_rem == 0) begin
          for (int k = 0; k < 4; k++) begin
            if (wr_en[k]) begin
              mem_m[wr_addr][k*8 +: 8] = wr_data[k*8 +: 8];
              bad_m[wr_addr][k]        = 1'b0;
            end
          end
        end
        en_cnt++;
      end else begin
        edge_kind = 2;
      end
      if (clr_rem > 0) begin
        clr_rem--;
        if (clr_rem == 0) begin
          for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = INIT;
            bad_m[a] = 4'h0;
          end
        end
      end
    end
  end

  // Word seen by read r: array value at issue, then every write accepted in the
  // RD_LAT enabled cycles starting at the issue cycle, oldest first.
  task automatic expect_for(input int r, input int lat,
                            output logic [31:0] d, output logic [3:0] e);
    d = rd_base[r];
    e = rd_bad[r];
    for (int j = rd_n[r]; j < rd_n[r] + lat && j < MAXN; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (wl_en[j][k] && wl_addr[j] == rd_a[r]) begin
          d[k*8 +: 8] = wl_data[j][k*8 +: 8];
          e[k]        = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int lat,
                     input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (RD_LAT=%0d) at %0t: got %h, want %h", name, lat, $time, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 3 : ((g == 1) ? 1 : 8);

    zap_ram_pipe_ben_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    assign bus.i_clken   = clken;
    assign bus.i_wr_en   = wr_en;
    assign bus.i_wr_addr = wr_addr;
    assign bus.i_wr_data = wr_data;
    assign bus.i_rd_en   = rd_en;
    assign bus.i_rd_addr = rd_addr;

    zap_ram_pipe_ben #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RD_LAT   (L),
      .INIT_VAL (INIT)
    ) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
    );

    int          ptr   = 0;
    logic [31:0] exp_d = '0;
    logic        exp_v = 1'b0;
    logic [3:0]  exp_e = '0;

    always @(negedge clk) begin
      if (edge_kind == 0) begin
        exp_v = 1'b0;
        exp_d = '0;
        exp_e = '0;
        ptr   = rd_cnt;
      end else if (edge_kind == 1) begin
        if (ptr < rd_cnt && rd_n[ptr] + int'(L) - 1 == edge_idx) begin
          exp_v = 1'b1;
          expect_for(ptr, int'(L), exp_d, exp_e);
          ptr++;
        end else begin
          exp_v = 1'b0;
        end
      end
      if (edge_kind >= 0) begin
        chk("rd_valid", int'(L), {31'b0, bus.o_rd_valid}, {31'b0, exp_v});
        chk("rd_data", int'(L), bus.o_rd_data, exp_d);
        chk("busy", int'(L), {31'b0, bus.o_busy}, {31'b0, clr_rem != 0});
`ifdef ZAP_RAM_PIPE_PARITY_EN
        chk("par_err", int'(L), {28'b0, bus.o_par_err}, {28'b0, exp_e});
`endif
      end
    end
  end

  task automatic drive(input logic ce, input logic [3:0] we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic re, input logic [4:0] ra);
    clken   = ce;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_en   = re;
    rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  task automatic wait_clear();
    int b;
    b = 0;
    while (clr_rem != 0 && b < 200) begin
      idle(1);
      b++;
    end
    if (clr_rem != 0) chk("clear_timeout", 0, 32'(clr_rem), 32'd0);
  endtask

  initial begin
    logic [4:0] a1, a2;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    wait_clear();

    // Every address returns INIT_VAL after the clear.
    for (int a = 0; a < DEPTH; a++) drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'(a));
    idle(10);

    // Write then read on the next cycle.
    drive(1'b1, 4'hF, 5'd5, 32'hAABB_CCDD, 1'b0, 5'd0);
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5);
    idle(10);

    // Bytewise forwarding from three successive partial writes.
    drive(1'b1, 4'hF, 5'd7, 32'h1122_3344, 1'b0, 5'd0);
    idle(10);
    drive(1'b1, 4'b0001, 5'd7, 32'h0000_00EE, 1'b1, 5'd7);
    drive(1'b1, 4'b0100, 5'd7, 32'h00FF_0000, 1'b0, 5'd0);
    drive(1'b1, 4'b1000, 5'd7, 32'h9900_0000, 1'b0, 5'd0);
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd7);
    idle(12);

    // Stall mid-flight: requests and writes during clken=0 must be ignored.
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5);
    for (int i = 0; i < 4; i++) drive(1'b0, 4'hF, 5'd5, 32'h0BAD_0BAD, 1'b1, 5'd7);
    idle(12);
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd5);
    idle(12);

`ifdef ZAP_RAM_PIPE_PARITY_EN
    // Flip one stored parity bit, read it back, then heal the byte by forwarding.
    g_dut[0].u_dut.par_mem[9][2] = ~g_dut[0].u_dut.par_mem[9][2];
    g_dut[1].u_dut.par_mem[9][2] = ~g_dut[1].u_dut.par_mem[9][2];
    g_dut[2].u_dut.par_mem[9][2] = ~g_dut[2].u_dut.par_mem[9][2];
    bad_m[9][2] = 1'b1;
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd9);
    idle(12);
    drive(1'b1, 4'b0100, 5'd9, 32'h0077_0000, 1'b1, 5'd9);
    idle(12);
`endif

    // Reset at clear counter 10 restarts the full clear; busy-time writes are dropped.
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int b = 0; b < 100 && clr_rem > DEPTH - 10; b++) begin
      drive(1'b1, 4'hF, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd3);
    end
    rst_n = 1'b0;
    drive(1'b1, 4'hF, 5'd3, 32'hDEAD_BEEF, 1'b1, 5'd3);
    rst_n = 1'b1;
    for (int b = 0; b < 100 && clr_rem != 0; b++) begin
      drive(1'b1, 4'hF, 5'd3, 32'hFEED_F00D, 1'b1, 5'd3);
    end
    drive(1'b1, 4'h0, 5'd0, 32'h0, 1'b1, 5'd3);
    idle(12);

    // Randomised traffic, biased toward a few hot addresses.
    for (int i = 0; i < 400; i++) begin
      a1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 99) < 85, 4'($urandom), a1, $urandom,
            1'($urandom_range(0, 1)), a2);
    end
    idle(14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
